inv_mixrow_seq: RTL and testbench
=================================

INV_MIXROW_SEQ -- requirements
Module: inv_mixrow_seq

Interface
REQ-001 SHALL have parameter POLY, default 4'h3, meaning the low 4 bits of the GF(2^4) reduction polynomial (x^4+x+1).
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  in_state holds a cipher state to un-mix.
REQ-005 SHALL have port in_ready  output  1  block can accept a state.
REQ-006 SHALL have port in_state  input  64  4x4 nibble state; element [j][k] at bits [63-4*(4j+k) -: 4].
REQ-007 SHALL have port out_valid  output  1  out_state holds a result.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-009 SHALL have port out_state  output  64  result state, same packing as in_state.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 SHALL compute the decryption-side row mix out[j][k] = XOR over l of gmul(s[j][l], M[l][k]), with M rows {1,4,9,13},{4,1,13,9},{9,13,1,4},{13,9,4,1}; M is involutory, so M is its own inverse.
REQ-012 SHALL implement gmul as full 4x4 carry-less multiply reduced modulo x^4 + POLY, giving a 4-bit result; bits above 3 SHALL never be truncated without reduction.
REQ-013 SHALL use FSM states IDLE, CALC, DONE.
REQ-014 IDLE: in_ready=1; on in_valid&&in_ready, SHALL register in_state, clear row counter to 0 and go to CALC.
REQ-015 CALC: SHALL compute one output row per cycle, row index = counter 0..3; after row 3 SHALL go to DONE; in_ready=0.
REQ-016 Latency: for acceptance at edge t, out_valid SHALL rise after edge t+4.
REQ-017 DONE: out_valid=1 and out_state stable until out_valid&&out_ready; then SHALL go to IDLE.
REQ-018 in_ready SHALL be 0 in CALC and DONE (no input overlap); in_valid there SHALL be ignored and in_state not sampled.
REQ-019 out_ready held low SHALL stall DONE indefinitely with out_state unchanged.
REQ-020 Changes on in_state after acceptance SHALL not affect the result.
REQ-021 A new state SHALL be acceptable no earlier than the cycle after the DONE handshake (IDLE for one cycle minimum).

Reset
REQ-022 rst low SHALL immediately force IDLE, counter=0, out_valid=0, busy=0, in_ready=1 (after release), out_state=64'h0, regardless of clock.
REQ-023 Reset asserted mid-CALC or in DONE SHALL discard the operation; no out_valid SHALL follow.
REQ-024 First acceptance SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-025 Macro INV_MIXROW_PARALLEL_EN defined: CALC SHALL compute all four rows in one cycle, out_valid rising after edge t+1; counter unused.
REQ-026 Macro undefined: serial one-row-per-cycle behaviour of REQ-015/REQ-016; results SHALL be bit-identical in both builds.

Verification
REQ-027 Reset mid-CALC (assert rst at cycle t+2) -> out_valid stays 0, out_state=0, in_ready=1 after release.
REQ-028 in_state=64'h1000_0000_0000_0000 -> out_state=64'h149D_0000_0000_0000 after 4 cycles (1 cycle with INV_MIXROW_PARALLEL_EN).
REQ-029 in_state=64'h1111_1111_1111_1111 -> out_state=64'h1111_1111_1111_1111; in_state=0 -> out_state=0.
REQ-030 Involution: random state X fed, result fed back in -> second result equals X, 1000 random vectors.
REQ-031 out_ready held low 10 cycles in DONE while in_valid=1 with new data -> out_state unchanged, in_ready=0, no new acceptance until handshake.
REQ-032 Back-to-back states with out_ready=1 -> each accepted exactly once, results in order, one IDLE cycle between.

Source files
------------

// File: rtl/inv_mixrow_seq.sv
`default_nettype none
// inv_mixrow_seq: decryption-side GF(2^4) row mix of a 4x4 nibble state, one row per CALC cycle.
// Build macro INV_MIXROW_PARALLEL_EN: compute all four rows in a single CALC cycle (results identical).
module inv_mixrow_seq #(
  parameter logic [3:0] POLY = 4'h3
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_state,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_state,
  output logic        busy
);

  // Mix matrix M[l][k], row-major, one nibble per entry.
  localparam logic [63:0] M_FLAT = 64'h149D_41D9_9D14_D941;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] src;

  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ (7'(a) << i);
    end
    // Fold the high product bits back down, top bit first.
    for (int i = 6; i >= 4; i--) begin
      if (p[i]) p = p ^ (7'({1'b1, POLY}) << (i - 4));
    end
    return p[3:0];
  endfunction

  function automatic logic [15:0] mix_row(input logic [15:0] r);
    logic [15:0] res;
    logic [3:0]  acc;
    res = '0;
    for (int k = 0; k < 4; k++) begin
      acc = '0;
      for (int l = 0; l < 4; l++) begin
        acc = acc ^ gmul(r[15-4*l -: 4], M_FLAT[63-4*(4*l+k) -: 4]);
      end
      res[15-4*k -: 4] = acc;
    end
    return res;
  endfunction

`ifdef INV_MIXROW_PARALLEL_EN
  function automatic logic [63:0] mix_all(input logic [63:0] s);
    logic [63:0] res;
    res = '0;
    for (int j = 0; j < 4; j++) begin
      res[63-16*j -: 16] = mix_row(s[63-16*j -: 16]);
    end
    return res;
  endfunction
`else
  logic [1:0]  cnt;
  logic [15:0] row_in;
  logic [15:0] row_out;

  assign row_in  = src[63-16*int'(cnt) -: 16];
  assign row_out = mix_row(row_in);
`endif

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      src       <= '0;
      out_state <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
`ifndef INV_MIXROW_PARALLEL_EN
      cnt       <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            src      <= in_state;
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifndef INV_MIXROW_PARALLEL_EN
            cnt      <= 2'd0;
`endif
          end
        end
        CALC: begin
`ifdef INV_MIXROW_PARALLEL_EN
          out_state <= mix_all(src);
          state     <= DONE;
          out_valid <= 1'b1;
`else
          out_state[63-16*int'(cnt) -: 16] <= row_out;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inv_mixrow_seq.sv
`default_nettype none
// tb_inv_mixrow_seq: directed + random checks of inv_mixrow_seq against a GF(2^4) matrix reference.
module tb_inv_mixrow_seq;

`ifdef INV_MIXROW_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif
  localparam logic [3:0] POLY = 4'h3;

  logic        clock = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_state;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_state;
  logic        busy;

  int errors = 0;
  int checks = 0;

  inv_mixrow_seq #(.POLY(POLY)) dut (
    .clock    (clock),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_state (in_state),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_state(out_state),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference: field multiply by repeated doubling, then plain matrix product.
  function automatic logic [3:0] ref_gmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    logic [3:0] x;
    r = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ x;
      x = x[3] ? ({x[2:0], 1'b0} ^ POLY) : {x[2:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [63:0] ref_mix(input logic [63:0] s);
    int          m [4][4];
    logic [3:0]  e [4][4];
    logic [3:0]  acc;
    logic [63:0] res;
    m = '{'{1, 4, 9, 13}, '{4, 1, 13, 9}, '{9, 13, 1, 4}, '{13, 9, 4, 1}};
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++)
        e[j][k] = s[63-4*(4*j+k) -: 4];
    res = '0;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++) begin
        acc = '0;
        for (int l = 0; l < 4; l++) acc = acc ^ ref_gmul(e[j][l], 4'(m[l][k]));
        res[63-4*(4*j+k) -: 4] = acc;
      end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Entered at a negedge with the DUT idle; leaves at a negedge with the DUT idle again.
  task automatic run(input logic [63:0] x, output logic [63:0] y);
    int edges;
    in_valid  = 1'b1;
    in_state  = x;
    out_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    in_state = rnd64();
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      in_state = rnd64();
    end
    chk("latency", 64'(edges), 64'(LAT));
    y = out_state;
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  logic [63:0] x, y, z, a, snap;
  logic [63:0] bb [8];
  logic [63:0] expq [$];
  int idx, got, cyc, last_hs;
  logic acc, hs;

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_state", out_state, 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // First acceptance on the first edge after release.
    @(negedge clock);
    rst = 1'b1;
    run(64'h1000_0000_0000_0000, y);
    chk("unit_row", y, 64'h149D_0000_0000_0000);
    run(64'h1111_1111_1111_1111, y);
    chk("all_ones", y, 64'h1111_1111_1111_1111);
    run(64'h0, y);
    chk("zero", y, 64'h0);
    run(64'h0000_0000_0000_0002, y);
    chk("last_nibble", y, ref_mix(64'h0000_0000_0000_0002));

    // Stall in DONE with new data offered.
    a = rnd64();
    in_valid = 1'b1;
    in_state = a;
    @(posedge clock);
    @(negedge clock);
    in_state = rnd64();
    chk("calc_busy", 64'(busy), 64'd1);
    chk("calc_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clock);
      @(negedge clock);
      in_state = rnd64();
    end
    chk("stall_first", out_state, ref_mix(a));
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      @(negedge clock);
      in_state = rnd64();
      chk("stall_state", out_state, ref_mix(a));
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("post_hs_busy", 64'(busy), 64'd0);
    chk("post_hs_in_ready", 64'(in_ready), 64'd1);
    chk("post_hs_valid", 64'(out_valid), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Back-to-back stream with out_ready held high.
    for (int i = 0; i < 8; i++) bb[i] = rnd64();
    idx = 0; got = 0; cyc = 0; last_hs = -10;
    in_valid  = 1'b1;
    in_state  = bb[0];
    out_ready = 1'b1;
    while (got < 8 && cyc < 200) begin
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) begin
        if (expq.size() == 0) chk("bb_extra_out", out_state, 64'h0 ^ ~out_state);
        else chk("bb_result", out_state, expq.pop_front());
        got++;
        last_hs = cyc;
      end
      if (acc) begin
        expq.push_back(ref_mix(bb[idx]));
        if (idx > 0) chk("bb_gap", 64'(cyc - last_hs), 64'd1);
        idx++;
      end
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (idx < 8) in_state = bb[idx];
      else begin
        in_valid = 1'b0;
        in_state = rnd64();
      end
    end
    chk("bb_accepted", 64'(idx), 64'd8);
    chk("bb_delivered", 64'(got), 64'd8);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);

    // Reset two edges into CALC discards the operation.
    in_valid = 1'b1;
    in_state = rnd64() | 64'h1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_state", out_state, 64'h0);
    @(negedge clock);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk("mid_rst_no_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    end

    // Reset while holding a result in DONE.
    in_valid = 1'b1;
    in_state = 64'h1000_0000_0000_0000;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
    chk("done_before_rst", out_state, 64'h149D_0000_0000_0000);
    rst = 1'b0;
    #1;
    chk("done_rst_state", out_state, 64'h0);
    chk("done_rst_valid", 64'(out_valid), 64'd0);
    @(negedge clock);
    rst = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("done_rst_in_ready", 64'(in_ready), 64'd1);
    chk("done_rst_no_valid", 64'(out_valid), 64'd0);

    // Involution over random states.
    for (int n = 0; n < 1000; n++) begin
      x = rnd64();
      run(x, y);
      chk("rand_mix", y, ref_mix(x));
      run(y, z);
      chk("involution", z, x);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
